ma_result_collector: RTL and testbench
======================================

Name: ma_result_collector

Overview:
Sink-side companion to the moving-average filter: consumes the filter's result strobe (in_pulse) and result word (in_data).
- Optionally decimates the strobes.
- Buffers accepted results in a small FIFO.
- Presents them downstream on a valid/ready stream.
- Tracks drops (overflow) and the number of accepted samples.
- Sits between the filter output and the logging/host readout path.

Parameters:
DATA_WIDTH, 16, width of in_data and m_data (two's complement, passed through unmodified)
FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2
ADDR_WIDTH, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  synchronous flush: empties FIFO, clears overflow, sample_count, decimation counter
in_pulse  input  1  result strobe from filter; one cycle per result
in_data  input  DATA_WIDTH  result word, valid only while in_pulse=1
decim  input  4  keep one of every (decim+1) strobes; 0 = keep all
m_valid  output  1  FIFO head available
m_data  output  DATA_WIDTH  FIFO head word
m_ready  input  1  downstream accept; transfer when m_valid && m_ready
fifo_level  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: an accepted (post-decimation) sample was dropped because FIFO was full
sample_count  output  16  number of samples written to FIFO, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0, async): FIFO empty, read/write pointers 0, fifo_level=0, m_valid=0, m_data=0, overflow=0, sample_count=0, decimation counter=0.
- Decimation:
  - dcnt is 4-bit; it only changes on cycles with in_pulse=1.
  - On in_pulse: if dcnt >= decim, the sample is selected and dcnt<=0; otherwise dcnt<=dcnt+1 and the sample is discarded (this does not count as overflow).
  - The >= compare covers a shrinking decim mid-sequence: the next pulse selects.
- Write: a selected sample is written at the rising edge of the in_pulse cycle, provided the FIFO is not full or a pop occurs in the same cycle.
- Full with no pop: sample dropped, overflow<=1, sample_count unchanged, FIFO contents unchanged.
- Full with simultaneous pop (m_valid && m_ready): write accepted; fifo_level stays FIFO_DEPTH.
- Read: first-word-fall-through.
  - m_valid = (fifo_level != 0).
  - m_data = entry at read pointer, combinational from the storage array.
  - On m_valid && m_ready, the read pointer advances at the edge.
  - m_ready while m_valid=0 has no effect.
  - m_data is don't-care while m_valid=0; the bench must not check it.
- Latency: a sample selected in cycle N is visible with m_valid=1 in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop with a non-empty, non-full FIFO: both occur; level unchanged; order preserved (strict FIFO).
- Pointers are ADDR_WIDTH bits and wrap modulo FIFO_DEPTH. fifo_level is a separate counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- sample_count: +1 per FIFO write; holds at 16'hFFFF (no wrap).
- overflow: sticky until clear or reset.
- clear (synchronous) has priority over everything in the same cycle:
  - pointers, level, overflow, sample_count and dcnt go to 0.
  - an in_pulse in the clear cycle is ignored (neither counted nor stored).
  - a pop in the clear cycle is discarded.
- Reset asserted mid-operation: state returns to reset values immediately; no partial transfer is required.
- decim may change at any time; the new value takes effect on the next in_pulse compare.

Test Plan:
- decim=0; pulses with data 0x0001, 0xFFFE, 0x7FFF; m_ready=1 -> m_data sequence 0x0001, 0xFFFE, 0x7FFF, each with m_valid one cycle after its pulse; sample_count=3; overflow=0.
- decim=2; 9 pulses with data 1..9; m_ready=1 -> outputs 3, 6, 9 only; sample_count=3.
- FIFO_DEPTH=8, m_ready=0; 10 pulses with data 10..19 -> fifo_level=8, overflow=1, sample_count=8; then m_ready=1 -> drains exactly 10..17 in order, and fifo_level reaches 0.
- FIFO full (8 entries), then a pulse with data 0x00AA in the same cycle as m_ready=1 -> head popped, 0x00AA stored as the last entry, fifo_level stays 8, overflow unchanged.
- 4 entries held and overflow=1; assert clear in the same cycle as a pulse with data 0x1234 -> next cycle fifo_level=0, m_valid=0, overflow=0, sample_count=0; 0x1234 never appears on m_data.
- Drive 65537 pulses with decim=0 and m_ready=1 -> sample_count saturates at 0xFFFF; assert rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ma_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : ma_result_collector
// Description : Collects moving-average filter results. Optionally decimates
//               the result strobes, buffers kept samples in a first-word-
//               fall-through FIFO, presents them on a valid/ready stream and
//               tracks dropped samples and the number of stored samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ma_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_pulse,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [3:0]            decim,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  overflow,
    output logic [15:0]           sample_count
);

    localparam logic [ADDR_WIDTH:0]   c_level_full = FIFO_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   c_level_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic [15:0]           r_count;
    logic [3:0]            r_dcnt;

    logic w_select;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Decimation, FIFO handshake and drop decisions for the current cycle.
    always_comb begin
        w_select = in_pulse && (r_dcnt >= decim);
        w_full   = (r_level == c_level_full);
        w_pop    = (r_level != '0) && m_ready;
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        w_push   = w_select && (!w_full || w_pop);
        w_drop   = w_select && w_full && !w_pop;
    end

    assign m_valid      = (r_level != '0);
    assign m_data       = r_mem[r_rd_ptr];
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;
    assign sample_count = r_count;

    // Control state: pointers, occupancy, statistics and decimation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_dcnt     <= '0;
        end else if (clear) begin
            // Flush wins over any strobe or pop arriving in the same cycle.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_dcnt     <= '0;
        end else begin
            if (in_pulse) begin
                r_dcnt <= w_select ? 4'd0 : r_dcnt + 4'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_level_one;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_level_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sample storage; cleared on reset so the head word reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clear && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ma_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ma_result_collector
// Description : Self-checking bench for ma_result_collector: vector table,
//               directed corner-case sequences and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ma_result_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_pulse;
    logic [DW-1:0] in_data;
    logic [3:0]    decim;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [15:0]   sample_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic          m_ov;
    int            m_cnt;
    int            m_dcnt;

    typedef struct {
        logic          clr;
        logic          pulse;
        logic [DW-1:0] data;
        logic [3:0]    dec;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        int            el;
        logic          eov;
        int            ecnt;
    } vec_t;
    vec_t vecs[$];

    ma_result_collector #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_pulse(in_pulse),
        .in_data(in_data),
        .decim(decim),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ov   = 1'b0;
        m_cnt  = 0;
        m_dcnt = 0;
    endfunction

    // One clock edge of the specified behaviour, stated on the queue.
    function automatic void model_edge(input logic clr, input logic pulse, input logic [DW-1:0] data,
                                       input logic [3:0] dec, input logic rdy);
        bit sel;
        if (clr) begin
            model_reset();
            return;
        end
        sel = pulse && (m_dcnt >= int'(dec));
        if (pulse) m_dcnt = sel ? 0 : m_dcnt + 1;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (sel) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(data);
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ov = 1'b1;
            end
        end
    endfunction

    task automatic check_model();
        check("m_valid", {31'b0, m_valid}, {31'b0, mq.size() != 0});
        if (mq.size() > 0) check("m_data", {16'b0, m_data}, {16'b0, mq[0]});
        check("fifo_level", {28'b0, fifo_level}, mq.size());
        check("overflow", {31'b0, overflow}, {31'b0, m_ov});
        check("sample_count", {16'b0, sample_count}, m_cnt);
    endtask

    // Drive one cycle, advance the model at the edge, check just after it.
    task automatic step(input logic clr, input logic pulse, input logic [DW-1:0] data,
                        input logic [3:0] dec, input logic rdy);
        clear    = clr;
        in_pulse = pulse;
        in_data  = data;
        decim    = dec;
        m_ready  = rdy;
        @(posedge clk);
        model_edge(clr, pulse, data, dec, rdy);
        #1;
        check_model();
    endtask

    function automatic void add(input logic clr, input logic pulse, input logic [DW-1:0] data,
                                input logic [3:0] dec, input logic rdy, input logic ev,
                                input logic [DW-1:0] ed, input int el, input logic eov, input int ecnt);
        vec_t v;
        v.clr = clr; v.pulse = pulse; v.data = data; v.dec = dec; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.eov = eov; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_pulse = 1'b0;
        in_data  = '0;
        decim    = '0;
        m_ready  = 1'b0;
        model_reset();

        // Expected outputs after each vector's clock edge.
        add(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0);
        add(0, 1, 16'h0001, 0, 1, 1, 16'h0001, 1, 0, 1);
        add(0, 1, 16'hFFFE, 0, 1, 1, 16'hFFFE, 1, 0, 2);
        add(0, 1, 16'h7FFF, 0, 1, 1, 16'h7FFF, 1, 0, 3);
        add(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 3);
        add(1, 0, 16'h0000, 2, 1, 0, 16'h0000, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            add(0, 1, 16'(k), 2, 1, (k % 3) == 0, 16'(k), ((k % 3) == 0) ? 1 : 0, 0, k / 3);
        end
        add(0, 0, 16'h0000, 2, 1, 0, 16'h0000, 0, 0, 3);

        #12;
        check("rst m_valid", {31'b0, m_valid}, 32'd0);
        check("rst m_data", {16'b0, m_data}, 32'd0);
        check("rst fifo_level", {28'b0, fifo_level}, 32'd0);
        check("rst overflow", {31'b0, overflow}, 32'd0);
        check("rst sample_count", {16'b0, sample_count}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].pulse, vecs[i].data, vecs[i].dec, vecs[i].rdy);
            check($sformatf("vec%0d m_valid", i), {31'b0, m_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) check($sformatf("vec%0d m_data", i), {16'b0, m_data}, {16'b0, vecs[i].ed});
            check($sformatf("vec%0d level", i), {28'b0, fifo_level}, vecs[i].el);
            check($sformatf("vec%0d overflow", i), {31'b0, overflow}, {31'b0, vecs[i].eov});
            check($sformatf("vec%0d count", i), {16'b0, sample_count}, vecs[i].ecnt);
        end

        // Overflow: 10 pulses into a stalled FIFO, then drain
        step(1, 0, 0, 0, 0);
        for (int k = 10; k <= 19; k++) step(0, 1, 16'(k), 0, 0);
        check("ovf level", {28'b0, fifo_level}, 32'd8);
        check("ovf flag", {31'b0, overflow}, 32'd1);
        check("ovf count", {16'b0, sample_count}, 32'd8);
        for (int k = 10; k <= 17; k++) begin
            check("drain head", {16'b0, m_data}, k);
            step(0, 0, 0, 0, 1);
        end
        check("drain level", {28'b0, fifo_level}, 32'd0);

        // Full FIFO with a write and a pop in the same cycle
        for (int k = 20; k <= 27; k++) step(0, 1, 16'(k), 0, 0);
        step(0, 1, 16'h00AA, 0, 1);
        check("fullpop level", {28'b0, fifo_level}, 32'd8);
        check("fullpop head", {16'b0, m_data}, 32'd21);
        check("fullpop overflow", {31'b0, overflow}, 32'd1);
        for (int k = 21; k <= 27; k++) begin
            check("fullpop drain", {16'b0, m_data}, k);
            step(0, 0, 0, 0, 1);
        end
        check("fullpop last", {16'b0, m_data}, 32'h00AA);
        step(0, 0, 0, 0, 1);

        // Clear with a coincident pulse while holding 4 entries and overflow set
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(0, 1, 16'(16'h0100 + k), 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        check("preclr level", {28'b0, fifo_level}, 32'd4);
        check("preclr overflow", {31'b0, overflow}, 32'd1);
        step(1, 1, 16'h1234, 0, 1);
        check("clr level", {28'b0, fifo_level}, 32'd0);
        check("clr m_valid", {31'b0, m_valid}, 32'd0);
        check("clr overflow", {31'b0, overflow}, 32'd0);
        check("clr count", {16'b0, sample_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1);
            check("clr stays empty", {31'b0, m_valid}, 32'd0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), 16'($urandom),
                 4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        end

        // Saturation of sample_count, then asynchronous reset mid-stream
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 65537; k++) step(0, 1, 16'($urandom), 0, 1);
        check("sat count", {16'b0, sample_count}, 32'h0000FFFF);
        step(0, 1, 16'h5A5A, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async m_valid", {31'b0, m_valid}, 32'd0);
        check("async m_data", {16'b0, m_data}, 32'd0);
        check("async level", {28'b0, fifo_level}, 32'd0);
        check("async overflow", {31'b0, overflow}, 32'd0);
        check("async count", {16'b0, sample_count}, 32'd0);
        model_reset();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 1, 16'(16'h0200 + k), 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
